// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-expansion sequencer.
// Loads a 128-bit cipher key and produces one round key per cycle into an
// 11-entry round-key store. SubWord is done by an external combinational
// S-box bank, so no substitution tables live in this block.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | after reset, no key loaded, store holds zeros
// ST_EXPAND | computing rk[rnd] from the working words, one round per cycle
// ST_READY  | all 11 round keys valid for the last loaded key
module aes_key_sched_ctrl (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_ld,
    input  logic [127:0] key,
    output logic [31:0]  sb_in,
    input  logic [31:0]  sb_out,
    output logic         busy,
    output logic         done,
    output logic         key_rdy,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_key
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_EXPAND = 2'd1;
    localparam logic [1:0] ST_READY  = 2'd2;

    localparam logic [3:0] LAST_RND  = 4'd10;
    localparam int         NUM_RK    = 11;

    logic [1:0]   state;
    logic [127:0] w;
    logic [3:0]   rnd;
    logic [127:0] rk [0:NUM_RK-1];

    logic [7:0]   rcon;
    logic [31:0]  t;
    logic [31:0]  w0_next;
    logic [31:0]  w1_next;
    logic [31:0]  w2_next;
    logic [31:0]  w3_next;
    logic [127:0] w_next;
    logic [127:0] rd_mux;
    logic         expand_step;

    // RotWord of w3 goes straight to the shared S-box bank; w is zero after reset
    assign sb_in = {w[23:0], w[31:24]};

    // A load always wins over an in-flight round
    assign expand_step = (state == ST_EXPAND) && !key_ld;

    // Round constant for the round currently being computed
    always_comb begin
        rcon = 8'h00;
        case (rnd)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    // Next working words: XOR chain fed by the substituted, rcon-adjusted word
    always_comb begin
        t       = sb_out ^ {rcon, 24'h000000};
        w0_next = w[127:96] ^ t;
        w1_next = w[95:64]  ^ w0_next;
        w2_next = w[63:32]  ^ w1_next;
        w3_next = w[31:0]   ^ w2_next;
        w_next  = {w0_next, w1_next, w2_next, w3_next};
    end

    // Sequencer: load/restart, per-round stepping and completion flags
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            key_rdy <= 1'b0;
            w       <= '0;
            rnd     <= 4'd1;
        end else begin
            done <= 1'b0;
            if (key_ld) begin
                w       <= key;
                rnd     <= 4'd1;
                key_rdy <= 1'b0;
                busy    <= 1'b1;
                state   <= ST_EXPAND;
            end else if (state == ST_EXPAND) begin
                w <= w_next;
                if (rnd == LAST_RND) begin
                    rnd     <= 4'd1;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    key_rdy <= 1'b1;
                    state   <= ST_READY;
                end else begin
                    rnd <= rnd + 4'd1;
                end
            end
        end
    end

    // Round-key store: rk[0] takes the raw key, rk[rnd] the fresh round key
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_RK; i++) begin
                rk[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_RK; i++) begin
                if (key_ld && (i == 0)) begin
                    rk[i] <= key;
                end else if (expand_step && (i != 0) && (rnd == 4'(i))) begin
                    rk[i] <= w_next;
                end
            end
        end
    end

    // Read mux; indices beyond the store decode to zero
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_RK; i++) begin
            if (rd_idx == 4'(i)) begin
                rd_mux = rk[i];
            end
        end
    end

    // Registered read port, one cycle of latency in every state
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_key <= '0;
        end else begin
            rd_key <= rd_mux;
        end
    end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Bench for aes_key_sched_ctrl: S-box bank model, FIPS-197 reference key
// expansion, and a scoreboard for done timing and round-key reads.
module tb_aes_key_sched_ctrl;

    logic         clk;
    logic         rst;
    logic         key_ld;
    logic [127:0] key;
    logic [31:0]  sb_in;
    logic [31:0]  sb_out;
    logic         busy;
    logic         done;
    logic         key_rdy;
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;

    aes_key_sched_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .key_ld  (key_ld),
        .key     (key),
        .sb_in   (sb_in),
        .sb_out  (sb_out),
        .busy    (busy),
        .done    (done),
        .key_rdy (key_rdy),
        .rd_idx  (rd_idx),
        .rd_key  (rd_key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int edge_n = 0;

    logic [127:0] rd_q [$];
    int           done_q [$];
    logic         rd_vld = 1'b0;
    logic         rd_vld_d = 1'b0;
    logic [3:0]   rd_idx_d;
    logic [127:0] model_rk [0:10];

    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    // GF(2^8) arithmetic for the S-box model
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        logic hi;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
            b  = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] r, base, s;
        int e;
        r = 8'h01; base = a; e = 254;
        while (e != 0) begin
            if (e % 2 == 1) r = gmul(r, base);
            base = gmul(base, base);
            e = e / 2;
        end
        s = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
        return s;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

    // External S-box bank
    always_comb sb_out = sub_word(sb_in);

    // Reference expansion over the 44-word schedule
    task automatic expand_model(input logic [127:0] k);
        logic [31:0] wd [0:43];
        logic [31:0] tmp;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) wd[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = wd[i-1];
            if (i % 4 == 0) begin
                tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end
            wd[i] = wd[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++)
            model_rk[r] = {wd[4*r], wd[4*r+1], wd[4*r+2], wd[4*r+3]};
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    always @(posedge clk) begin
        edge_n   <= edge_n + 1;
        rd_vld_d <= rd_vld;
        rd_idx_d <= rd_idx;
    end

    // Monitor: compares presented outputs against queued expectations
    always @(negedge clk) begin
        if (rd_vld_d) begin
            if (rd_q.size() == 0) begin
                n_chk++; n_err++;
                $display("FAIL rd_unexpected: got %h expected no read", rd_key);
            end else begin
                chk($sformatf("rd_key[%0d]", rd_idx_d), rd_key, rd_q.pop_front());
            end
        end
        if (done === 1'b1) begin
            if (done_q.size() == 0) begin
                n_chk++; n_err++;
                $display("FAIL done_unexpected: got done=1 expected 0 (edge %0d)", edge_n);
            end else begin
                chk("done_edge", 128'(edge_n), 128'(done_q.pop_front()));
                chk("key_rdy_at_done", 128'(key_rdy), 128'(1));
                chk("busy_at_done", 128'(busy), 128'(0));
            end
        end else if (done_q.size() > 0 && done_q[0] <= edge_n) begin
            n_chk++; n_err++;
            $display("FAIL done_missing: got done=%b expected 1 at edge %0d", done, done_q.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic prune_pending();
        while (done_q.size() > 0 && done_q[$] > edge_n) void'(done_q.pop_back());
    endtask

    task automatic load(input logic [127:0] k, input int hold);
        for (int h = 0; h < hold; h++) begin
            key    = k;
            key_ld = 1'b1;
            prune_pending();
            done_q.push_back(edge_n + 11);
            step();
        end
        key_ld = 1'b0;
        key    = $urandom();
        expand_model(k);
        chk("busy_after_load", 128'(busy), 128'(1));
        chk("key_rdy_after_load", 128'(key_rdy), 128'(0));
        chk("sb_in_after_load", 128'(sb_in), 128'({k[23:0], k[31:24]}));
    endtask

    task automatic wait_rdy();
        for (int i = 0; i < 30 && key_rdy !== 1'b1; i++) step();
        chk("key_rdy_wait", 128'(key_rdy), 128'(1));
    endtask

    task automatic rd_one(input logic [3:0] idx, input logic [127:0] exp);
        rd_idx = idx;
        rd_vld = 1'b1;
        rd_q.push_back(exp);
        step();
        rd_vld = 1'b0;
    endtask

    task automatic rd_sweep();
        for (int i = 0; i < 16; i++)
            rd_one(4'(i), (i <= 10) ? model_rk[i] : 128'h0);
        step();
    endtask

    initial begin
        logic [127:0] rk_key;
        rst = 1'b0; key_ld = 1'b0; key = '0; rd_idx = '0;
        for (int r = 0; r < 11; r++) model_rk[r] = '0;

        // Reset state and read sweep while held in reset
        step(); step();
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_key_rdy", 128'(key_rdy), 128'(0));
        chk("rst_sb_in", 128'(sb_in), 128'(0));
        chk("rst_rd_key", rd_key, 128'h0);
        rd_sweep();
        rst = 1'b1;
        step();

        // FIPS-197 key
        load(FIPS_KEY, 1);
        wait_rdy();
        rd_one(4'd1, FIPS_RK1);
        rd_one(4'd10, FIPS_RK10);
        rd_sweep();

        // All-zero key
        load(128'h0, 1);
        wait_rdy();
        rd_one(4'd1, ZERO_RK1);
        rd_one(4'd10, ZERO_RK10);
        rd_sweep();

        // Restart: zero key, FIPS key four cycles later
        load(128'h0, 1);
        step(); step(); step();
        load(FIPS_KEY, 1);
        wait_rdy();
        rd_one(4'd10, FIPS_RK10);
        step();

        // Reset on cycle 6 of an expansion
        load({$urandom(), $urandom(), $urandom(), $urandom()}, 1);
        for (int i = 0; i < 5; i++) step();
        rst = 1'b0;
        prune_pending();
        step();
        rst = 1'b1;
        chk("midrst_busy", 128'(busy), 128'(0));
        chk("midrst_done", 128'(done), 128'(0));
        chk("midrst_key_rdy", 128'(key_rdy), 128'(0));
        chk("midrst_sb_in", 128'(sb_in), 128'(0));
        chk("midrst_rd_key", rd_key, 128'h0);
        for (int r = 0; r < 11; r++) model_rk[r] = '0;
        rd_sweep();
        load(FIPS_KEY, 1);
        wait_rdy();
        rd_sweep();

        // Randomized keys, held loads, occasional aborts, random reads
        for (int n = 0; n < 8; n++) begin
            rk_key = {$urandom(), $urandom(), $urandom(), $urandom()};
            if ($urandom_range(0, 1) == 1) begin
                load({$urandom(), $urandom(), $urandom(), $urandom()}, 1);
                for (int i = 0; i < int'($urandom_range(0, 9)); i++) step();
            end
            load(rk_key, int'($urandom_range(1, 3)));
            wait_rdy();
            for (int i = 0; i < 8; i++) begin
                rd_idx = 4'($urandom_range(0, 15));
                rd_one(rd_idx, (rd_idx <= 4'd10) ? model_rk[rd_idx] : 128'h0);
            end
            step();
        end

        for (int i = 0; i < 15 && done_q.size() > 0; i++) step();
        step();
        chk("done_q_drained", 128'(done_q.size()), 128'(0));
        chk("rd_q_drained", 128'(rd_q.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
